// File: rtl/ssidft_sched.sv
// Frame scheduler for the single-sample inverse DFT: reads one N-bin spectrum per request from a
// ping-pong RAM bank and streams it, framed by sob/eob, to the accumulator.
module ssidft_sched #(
  parameter int unsigned DW = 16,
  parameter int unsigned N  = 4096,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          enable_i,
  input  logic          tick_i,
  input  logic          bank_i,
  output logic          rd_en_o,
  output logic [AW:0]   rd_addr_o,
  input  logic [DW-1:0] rd_data_i,
  output logic          sob_o,
  output logic          eob_o,
  output logic [DW-1:0] freq_re_o,
  output logic          busy_o,
  output logic          overrun_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          bank_q, bank_d;
  logic          pend_q, pend_d;
  logic          drain_q, drain_d;
  logic          overrun_q, overrun_d;
  logic          v1_q, f1_q, l1_q;
  logic          sob_q, eob_q;
  logic [DW-1:0] freq_q;

  logic req, last_idx, consume, boundary, rd_en;

  assign req      = tick_i & enable_i;
  assign last_idx = (idx_q == AW'(N - 1));
  assign rd_en    = (state_q == StRead);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bank_d    = bank_q;
    pend_d    = pend_q;
    drain_d   = drain_q;
    overrun_d = 1'b0;
    consume   = 1'b0;
    boundary  = 1'b0;
    case (state_q)
      StIdle: begin
        boundary = 1'b1;
        if (enable_i && (tick_i || pend_q)) begin
          state_d = StRead;
          bank_d  = bank_i;
          idx_d   = '0;
          consume = 1'b1;
        end
      end
      StRead: begin
        idx_d = idx_q + AW'(1);
        if (last_idx) begin
          boundary = 1'b1;
          drain_d  = 1'b0;
          // Back-to-back frame: relatch the bank, the old frame drains underneath.
          if (pend_q && enable_i) begin
            bank_d  = bank_i;
            idx_d   = '0;
            consume = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) begin
          boundary = 1'b1;
          if (pend_q && enable_i) begin
            state_d = StRead;
            bank_d  = bank_i;
            idx_d   = '0;
            consume = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A tick landing on the consuming cycle is re-queued rather than dropped.
    if (!enable_i && boundary) begin
      pend_d = 1'b0;
    end else if (consume) begin
      pend_d = pend_q & req;
    end else if (req && state_q != StIdle) begin
      if (!pend_q) pend_d = 1'b1;
      else         overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      bank_q    <= 1'b0;
      pend_q    <= 1'b0;
      drain_q   <= 1'b0;
      overrun_q <= 1'b0;
      v1_q      <= 1'b0;
      f1_q      <= 1'b0;
      l1_q      <= 1'b0;
      sob_q     <= 1'b0;
      eob_q     <= 1'b0;
      freq_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bank_q    <= bank_d;
      pend_q    <= pend_d;
      drain_q   <= drain_d;
      overrun_q <= overrun_d;
      v1_q      <= rd_en;
      f1_q      <= rd_en & (idx_q == '0);
      l1_q      <= rd_en & last_idx;
      sob_q     <= v1_q & f1_q;
      eob_q     <= v1_q & l1_q;
      freq_q    <= v1_q ? rd_data_i : '0;
    end
  end

  assign rd_en_o   = rd_en;
  assign rd_addr_o = rd_en ? {bank_q, idx_q} : '0;
  assign sob_o     = sob_q;
  assign eob_o     = eob_q;
  assign freq_re_o = freq_q;
  assign busy_o    = (state_q != StIdle);
  assign overrun_o = overrun_q;

endmodule

// File: doc/ssidft_sched.md
# ssidft_sched

Frame scheduler for the single-sample inverse DFT accumulator. On each output-sample request it reads one complete N-bin spectrum from a ping-pong spectrum RAM and streams it, framed by start/end-of-block strobes, into the accumulator. It locks the RAM bank for the whole frame, queues at most one request while busy, and flags requests it has to drop. It sits between the SDFT spectrum buffer and the inverse-DFT datapath.

## Interface
- DW, 16, bin (real part) width, signed
- N, 4096, bins per frame, power of two, ≥4
- AW, $clog2(N), bin index width
- clk_i  in  1  system clock, all logic on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  accept new requests; deassert lets the running frame finish
- tick_i  in  1  output-sample request, one-cycle pulse
- bank_i  in  1  bank currently safe to read (driven by spectrum writer)
- rd_en_o  out  1  spectrum RAM read enable
- rd_addr_o  out  AW+1  {bank, bin index}
- rd_data_i  in  DW  RAM read data, signed, valid exactly 1 cycle after rd_en_o
- sob_o  out  1  first bin of frame to accumulator
- eob_o  out  1  last bin of frame to accumulator
- freq_re_o  out  DW  bin value to accumulator
- busy_o  out  1  frame in flight (reading or draining)
- overrun_o  out  1  one-cycle pulse: request dropped

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: on (tick_i & enable_i) or pending flag set → READ; latch bank_i into bank_q; index ← 0; clear pending.
- READ: rd_en_o=1, rd_addr_o={bank_q, index}; index increments by 1 per cycle; after index N-1 is issued → DRAIN, or directly READ again (new bank_q latched, index ← 0) if pending flag set and enable_i high (back-to-back frames).
- DRAIN: 2 cycles, until eob_o is emitted → IDLE (or READ if pending & enable_i).
- Pending: tick_i & enable_i while a frame is in flight and pending clear → set pending. tick_i & enable_i with pending already set → overrun_o pulse, request dropped, pending unchanged. A tick in the same cycle the machine consumes pending is queued (pending stays set).
- enable_i low: ticks ignored (no pending, no overrun); current frame completes; an existing pending request is discarded at the frame boundary.
- Datapath: 2-stage alignment pipeline (RAM latency + output register) carries valid/first/last flags; freq_re_o <= rd_data_i when valid, else 0. No arithmetic; data passes through unmodified, signed.
- bank_i changes mid-frame are ignored; every frame reads one bank only.
- Index wraps N-1 → 0 only via frame restart; never reads past N-1.

## Timing
- Reset (async assert, sync deassert handled upstream): state IDLE, pending 0, rd_en_o 0, rd_addr_o 0, sob_o 0, eob_o 0, freq_re_o 0, busy_o 0, overrun_o 0.
- Request accepted at cycle T (IDLE): rd_en_o high T+1..T+N, addr index 0..N-1; sob_o at T+3; eob_o at T+N+2; freq_re_o valid T+3..T+N+2.
- busy_o high T+1..T+N+2.
- Back-to-back: next frame rd_en_o at T+N+1, next sob_o at T+N+3 directly after eob_o (no gap); accumulator accepts this.
- Minimum request-to-sob latency: 3 cycles. Sustained throughput: one frame per N cycles.
- overrun_o registered: asserted the cycle after the dropping tick.
- Reset mid-frame: all outputs return to reset values immediately; no eob_o emitted; no partial frame resumed.

## Test plan
- N=8, single tick at T=10, bank_i=1 → rd_addr_o 8..15 at cycles 11..18; sob_o at 13; eob_o at 20; freq_re_o equals RAM contents in order; busy_o 11..20.
- Tick at T=10, second tick at T=14 → second frame rd_en_o 19..26, sob_o at 21 immediately after eob_o at 20; no overrun.
- Ticks at T=10, 12, 14 → third tick dropped, overrun_o at 15 only; exactly two frames emitted.
- bank_i toggles 0→1 at T=13 during frame started at T=10 with bank 0 → all 8 addresses use bank 0; next frame uses bank 1.
- enable_i low at T=12 with pending set → current frame finishes (eob_o at 20); no second frame; ticks at 25 ignored, overrun_o stays 0.
- rst_n_i asserted at T=15 mid-frame → outputs 0 in the same cycle; after release, tick at 30 yields a clean frame with sob_o at 33.
